// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Control and storage for the AES key schedule. The round-key arithmetic
// (RotWord/SubWord/Rcon XOR chain) lives in an external combinational
// datapath. Each expansion step sends that datapath the previous Nk words
// plus the round constant and stores the Nk words it returns in the same
// cycle. Once the schedule is complete, round keys are read back one
// 128-bit key per request.
//
// Parameters
//   Nk : key length in 32-bit words (4, 6 or 8)
//   Nr : cipher round count (10, 12 or 14, paired with Nk)
//
// Optional feature
//   KEYSCHED_DECRYPT_EN : adds input rk_dec. A read with rk_dec=1 returns
//                         round key Nr-rk_idx (inverse-cipher order).
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle request to expand key_in (ignored while busy)
//   key_in       : cipher key, word 0 in the MSBs
//   busy         : expansion steps in progress
//   done         : one-cycle pulse when the schedule is complete
//   key_ready    : stored schedule is valid for reads
//   exp_rcon     : round constant to the expansion datapath
//   exp_key_in   : previous Nk words to the expansion datapath
//   exp_key_out  : next Nk words from the expansion datapath
//   rk_rd        : round-key read request
//   rk_idx       : requested round index 0..Nr
//   rk_dec       : (KEYSCHED_DECRYPT_EN only) reverse the round index
//   rk_out       : registered round key, lowest-numbered word in the MSBs
//   rk_valid     : one-cycle flag marking rk_out as fresh read data
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Nk*32-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_ready,
    output logic [31:0]      exp_rcon,
    output logic [Nk*32-1:0] exp_key_in,
    input  logic [Nk*32-1:0] exp_key_out,
    input  logic             rk_rd,
    input  logic [3:0]       rk_idx,
`ifdef KEYSCHED_DECRYPT_EN
    input  logic             rk_dec,
`endif
    output logic [127:0]     rk_out,
    output logic             rk_valid
);

    // Total schedule size and the number of Nk-word expansion steps needed
    // to cover it (the final step may overshoot and is truncated).
    localparam int         NW     = 4 * (Nr + 1);
    localparam int         NSTEP  = (NW + Nk - 1) / Nk - 1;
    localparam logic [3:0] NSTEP4 = 4'(NSTEP);
    localparam logic [3:0] NR4    = 4'(Nr);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic [Nk*32-1:0]   prev_q, prev_d;
    logic               key_ready_q, key_ready_d;
    logic               rk_valid_q, rk_valid_d;
    logic [127:0]       rk_out_q, rk_out_d;
    logic [31:0]        words_q [0:NW-1];

    logic               key_load;
    logic               step_wr;
    logic [3:0]         rd_idx;
    logic [5:0]         rd_base;

    function automatic logic [31:0] rcon(input logic [3:0] s);
        logic [7:0] b;
        case (s)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

`ifdef KEYSCHED_DECRYPT_EN
    // Range is checked on rk_idx itself, so the subtraction never wraps
    // for an accepted read.
    assign rd_idx = rk_dec ? (NR4 - rk_idx) : rk_idx;
`else
    assign rd_idx = rk_idx;
`endif
    assign rd_base = {rd_idx, 2'b00};

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        prev_d      = prev_q;
        key_ready_d = key_ready_q;
        rk_valid_d  = 1'b0;
        rk_out_d    = rk_out_q;
        key_load    = 1'b0;
        step_wr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = EXPAND;
                    step_d      = 4'd1;
                    prev_d      = key_in;
                    key_ready_d = 1'b0;
                    key_load    = 1'b1;
                end
            end
            EXPAND: begin
                prev_d  = exp_key_out;
                step_wr = 1'b1;
                if (step_q == NSTEP4) begin
                    state_d     = FIN;
                    step_d      = 4'd0;
                    key_ready_d = 1'b1;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read coinciding with an accepted start sees a schedule that is
        // being replaced, so it is dropped even though key_ready_q is still 1.
        if (rk_rd && key_ready_q && !key_load && (rk_idx <= NR4)) begin
            rk_valid_d = 1'b1;
            rk_out_d   = {words_q[rd_base],         words_q[rd_base + 6'd1],
                          words_q[rd_base + 6'd2],  words_q[rd_base + 6'd3]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            rk_out_q    <= rk_out_d;
        end
    end

    // Data storage: no reset needed, contents are qualified by key_ready_q
    // and the exp_* outputs are gated by state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= prev_d;
            if (key_load) begin
                for (int j = 0; j < Nk; j++) begin
                    words_q[6'(j)] <= key_in[(Nk-1-j)*32 +: 32];
                end
            end
            if (step_wr) begin
                // The last step may run past the schedule end; those words
                // are not part of any round key and are dropped.
                for (int j = 0; j < Nk; j++) begin
                    if ((int'(step_q) * Nk + j) < NW) begin
                        words_q[6'(int'(step_q) * Nk + j)] <= exp_key_out[(Nk-1-j)*32 +: 32];
                    end
                end
            end
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = (state_q == FIN);
    assign key_ready  = key_ready_q;
    assign exp_key_in = busy ? prev_q : '0;
    assign exp_rcon   = busy ? rcon(step_q) : 32'h0;
    assign rk_out     = rk_out_q;
    assign rk_valid   = rk_valid_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//
// Bench for aes_key_sched_ctrl. Two instances: AES-128 (Nk=4, Nr=10) and
// AES-256 (Nk=8, Nr=14). Each is paired with a behavioural expansion
// datapath built from a locally generated S-box. Expected round keys
// come from published FIPS-197 vectors and from a word-by-word
// key-expansion model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start4, start8, rk_rd;
    logic [3:0]   rk_idx;
`ifdef KEYSCHED_DECRYPT_EN
    logic         rk_dec;
`endif
    logic [127:0] key4;
    logic [255:0] key8;

    logic         busy4, done4, key_ready4, rk_valid4;
    logic [31:0]  exp_rcon4;
    logic [127:0] exp_in4, exp_out4, rk_out4;

    logic         busy8, done8, key_ready8, rk_valid8;
    logic [31:0]  exp_rcon8;
    logic [255:0] exp_in8, exp_out8;
    logic [127:0] rk_out8;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  sbox   [256];
    logic [31:0] ref_w  [60];
    logic [7:0]  rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RKA  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [255:0] KEY256   =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_key_sched_ctrl #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key_in(key4),
        .busy(busy4), .done(done4), .key_ready(key_ready4),
        .exp_rcon(exp_rcon4), .exp_key_in(exp_in4), .exp_key_out(exp_out4),
        .rk_rd(rk_rd), .rk_idx(rk_idx),
`ifdef KEYSCHED_DECRYPT_EN
        .rk_dec(rk_dec),
`endif
        .rk_out(rk_out4), .rk_valid(rk_valid4)
    );

    aes_key_sched_ctrl #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key_in(key8),
        .busy(busy8), .done(done8), .key_ready(key_ready8),
        .exp_rcon(exp_rcon8), .exp_key_in(exp_in8), .exp_key_out(exp_out8),
        .rk_rd(rk_rd), .rk_idx(rk_idx),
`ifdef KEYSCHED_DECRYPT_EN
        .rk_dec(rk_dec),
`endif
        .rk_out(rk_out8), .rk_valid(rk_valid8)
    );

    // ---------------- GF(2^8) helpers and S-box ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // ---------------- external expansion datapaths ----------------
    function automatic logic [127:0] dp4(input logic [127:0] p, input logic [31:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = p[127:96] ^ subw({p[23:0], p[31:24]}) ^ rc;
        w1 = p[95:64] ^ w0;
        w2 = p[63:32] ^ w1;
        w3 = p[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [255:0] dp8(input logic [255:0] p, input logic [31:0] rc);
        logic [31:0] w [8];
        w[0] = p[255:224] ^ subw({p[23:0], p[31:24]}) ^ rc;
        w[1] = p[223:192] ^ w[0];
        w[2] = p[191:160] ^ w[1];
        w[3] = p[159:128] ^ w[2];
        w[4] = p[127:96]  ^ subw(w[3]);
        w[5] = p[95:64]   ^ w[4];
        w[6] = p[63:32]   ^ w[5];
        w[7] = p[31:0]    ^ w[6];
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
    endfunction

    assign exp_out4 = dp4(exp_in4, exp_rcon4);
    assign exp_out8 = dp8(exp_in8, exp_rcon8);

    // ---------------- reference key expansion (word by word) ----------------
    task automatic ref_expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int k = 1; k < i/nk; k++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if ({busy4, done4, key_ready4, rk_valid4} !== 4'b0000)
            $display("FAIL reset_ctrl4 got %b want 0000", {busy4, done4, key_ready4, rk_valid4}); else n_pass++;
        n_checks++; if (rk_out4 !== 128'h0)
            $display("FAIL reset_rk_out4 got %h want 0", rk_out4); else n_pass++;
        n_checks++; if ({exp_rcon4, exp_in4} !== 160'h0)
            $display("FAIL reset_exp4 got %h want 0", {exp_rcon4, exp_in4}); else n_pass++;
        n_checks++; if ({busy8, done8, key_ready8, rk_valid8} !== 4'b0000)
            $display("FAIL reset_ctrl8 got %b want 0000", {busy8, done8, key_ready8, rk_valid8}); else n_pass++;
        rst = 1'b0;
        rk_rd = 1'b1; rk_idx = 4'd0;
        tick();
        rk_rd = 1'b0;
        n_checks++; if (rk_valid4 !== 1'b0)
            $display("FAIL read_not_ready got %b want 0", rk_valid4); else n_pass++;
    endtask

    task automatic test_expand_128();
        key4 = FIPS_KEY;
        ref_expand({FIPS_KEY, 128'h0}, 4, 10);
        start4 = 1'b1;
        tick();                                   // edge T
        start4 = 1'b0;
        key4 = 128'h0;
        n_checks++; if (exp_in4 !== FIPS_KEY)
            $display("FAIL exp_key_in_first got %h want %h", exp_in4, FIPS_KEY); else n_pass++;
        for (int c = 1; c <= 10; c++) begin       // cycles T+1..T+10
            n_checks++; if ({busy4, done4, key_ready4} !== 3'b100)
                $display("FAIL busy_window c=%0d got %b want 100", c, {busy4, done4, key_ready4}); else n_pass++;
            n_checks++; if (exp_rcon4 !== {rc_exp[c-1], 24'h0})
                $display("FAIL rcon128 c=%0d got %h want %h", c, exp_rcon4, {rc_exp[c-1], 24'h0}); else n_pass++;
            tick();
        end
        n_checks++; if ({busy4, done4, key_ready4} !== 3'b011)       // T+11
            $display("FAIL done_T11 got %b want 011", {busy4, done4, key_ready4}); else n_pass++;
        n_checks++; if ({exp_rcon4, exp_in4} !== 160'h0)
            $display("FAIL exp_zero_fin got %h want 0", {exp_rcon4, exp_in4}); else n_pass++;
        tick();
        n_checks++; if ({busy4, done4, key_ready4} !== 3'b001)
            $display("FAIL idle_after_fin got %b want 001", {busy4, done4, key_ready4}); else n_pass++;
    endtask

    task automatic test_read();
        rk_rd = 1'b1; rk_idx = 4'd1; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_RK1})
            $display("FAIL read_idx1 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_RK1); else n_pass++;
        rk_idx = 4'd10; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_RKA})
            $display("FAIL read_idx10 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_RKA); else n_pass++;
        rk_idx = 4'd0; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_KEY})
            $display("FAIL read_idx0 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_KEY); else n_pass++;
        for (int r = 0; r <= 10; r++) begin
            rk_idx = 4'(r); tick();
            n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, ref_rk(r)})
                $display("FAIL read128_r%0d got %b/%h want 1/%h", r, rk_valid4, rk_out4, ref_rk(r)); else n_pass++;
        end
        rk_idx = 4'd11; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b0, ref_rk(10)})
            $display("FAIL read_idx11 got %b/%h want 0/%h", rk_valid4, rk_out4, ref_rk(10)); else n_pass++;
        rk_rd = 1'b0; rk_idx = 4'd2; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b0, ref_rk(10)})
            $display("FAIL no_read_hold got %b/%h want 0/%h", rk_valid4, rk_out4, ref_rk(10)); else n_pass++;
    endtask

    task automatic test_start_ignored();
        key4 = FIPS_KEY;
        start4 = 1'b1; tick();                    // edge T -> cycle T+1
        start4 = 1'b0; key4 = SEQ_KEY;
        tick(); tick(); tick();                   // cycle T+4
        start4 = 1'b1; tick();                    // edge T+5 ignored
        start4 = 1'b0;
        for (int c = 5; c <= 10; c++) begin
            n_checks++; if ({busy4, done4} !== 2'b10)
                $display("FAIL restart_busy c=%0d got %b want 10", c, {busy4, done4}); else n_pass++;
            tick();
        end
        n_checks++; if ({busy4, done4} !== 2'b01)
            $display("FAIL restart_done_T11 got %b want 01", {busy4, done4}); else n_pass++;
        start4 = 1'b1; tick();                    // start during FIN is ignored
        start4 = 1'b0;
        n_checks++; if ({busy4, done4, key_ready4} !== 3'b001)
            $display("FAIL start_in_fin got %b want 001", {busy4, done4, key_ready4}); else n_pass++;
        rk_rd = 1'b1; rk_idx = 4'd1; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_RK1})
            $display("FAIL restart_same_sched got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_RK1); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        key4 = SEQ_KEY;
        start4 = 1'b1; tick();                    // cycle T+1
        start4 = 1'b0;
        tick(); tick(); tick(); tick();           // cycle T+5
        rst = 1'b1; tick();                       // edge T+6
        rst = 1'b0;
        n_checks++; if ({busy4, done4, key_ready4} !== 3'b000)
            $display("FAIL abort_state got %b want 000", {busy4, done4, key_ready4}); else n_pass++;
        n_checks++; if ({exp_rcon4, exp_in4} !== 160'h0)
            $display("FAIL abort_exp got %h want 0", {exp_rcon4, exp_in4}); else n_pass++;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done4 === 1'b1 || busy4 === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++; if (saw_done !== 1'b0)
            $display("FAIL abort_no_done got %b want 0", saw_done); else n_pass++;
        rk_rd = 1'b1; rk_idx = 4'd3; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b0, 128'h0})
            $display("FAIL abort_read got %b/%h want 0/0", rk_valid4, rk_out4); else n_pass++;
    endtask

    task automatic test_read_with_start();
        key4 = SEQ_KEY;
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        n_checks++; if (done4 !== 1'b1)
            $display("FAIL seq_done got %b want 1", done4); else n_pass++;
        tick();
        rk_rd = 1'b1; rk_idx = 4'd10; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, SEQ_RKA})
            $display("FAIL seq_idx10 got %b/%h want 1/%h", rk_valid4, rk_out4, SEQ_RKA); else n_pass++;
        // Re-run with a new key while key_ready=1, with a read in the same cycle.
        key4 = FIPS_KEY;
        start4 = 1'b1; rk_rd = 1'b1; rk_idx = 4'd1; tick();
        start4 = 1'b0; rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, busy4, key_ready4} !== 3'b010)
            $display("FAIL read_at_start got %b want 010", {rk_valid4, busy4, key_ready4}); else n_pass++;
        n_checks++; if (rk_out4 !== SEQ_RKA)
            $display("FAIL read_at_start_hold got %h want %h", rk_out4, SEQ_RKA); else n_pass++;
        for (int c = 1; c <= 10; c++) tick();
        tick();
        rk_rd = 1'b1; rk_idx = 4'd10; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_RKA})
            $display("FAIL rerun_idx10 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_RKA); else n_pass++;
    endtask

    task automatic test_aes256();
        key8 = KEY256;
        ref_expand(KEY256, 8, 14);
        start8 = 1'b1; tick(); start8 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if ({busy8, done8} !== 2'b10)
                $display("FAIL busy256 c=%0d got %b want 10", c, {busy8, done8}); else n_pass++;
            n_checks++; if (exp_rcon8 !== {rc_exp[c-1], 24'h0})
                $display("FAIL rcon256 c=%0d got %h want %h", c, exp_rcon8, {rc_exp[c-1], 24'h0}); else n_pass++;
            tick();
        end
        n_checks++; if ({busy8, done8, key_ready8} !== 3'b011)
            $display("FAIL done256 got %b want 011", {busy8, done8, key_ready8}); else n_pass++;
        tick();
        rk_rd = 1'b1; rk_idx = 4'd1; tick();
        n_checks++; if ({rk_valid8, rk_out8} !== {1'b1, 128'h101112131415161718191a1b1c1d1e1f})
            $display("FAIL read256_idx1 got %b/%h want 1/101112131415161718191a1b1c1d1e1f", rk_valid8, rk_out8); else n_pass++;
        for (int r = 0; r <= 14; r++) begin
            rk_idx = 4'(r); tick();
            n_checks++; if ({rk_valid8, rk_out8} !== {1'b1, ref_rk(r)})
                $display("FAIL read256_r%0d got %b/%h want 1/%h", r, rk_valid8, rk_out8, ref_rk(r)); else n_pass++;
        end
        rk_idx = 4'd15; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid8, rk_out8} !== {1'b0, ref_rk(14)})
            $display("FAIL read256_idx15 got %b/%h want 0/%h", rk_valid8, rk_out8, ref_rk(14)); else n_pass++;
    endtask

`ifdef KEYSCHED_DECRYPT_EN
    task automatic test_decrypt();
        rk_rd = 1'b1; rk_dec = 1'b1; rk_idx = 4'd0; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_RKA})
            $display("FAIL dec_idx0 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_RKA); else n_pass++;
        rk_idx = 4'd10; tick();
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_KEY})
            $display("FAIL dec_idx10 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_KEY); else n_pass++;
        rk_dec = 1'b0; rk_idx = 4'd0; tick(); rk_rd = 1'b0;
        n_checks++; if ({rk_valid4, rk_out4} !== {1'b1, FIPS_KEY})
            $display("FAIL enc_idx0 got %b/%h want 1/%h", rk_valid4, rk_out4, FIPS_KEY); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0; rk_rd = 1'b0; rk_idx = 4'd0;
        key4 = '0; key8 = '0;
`ifdef KEYSCHED_DECRYPT_EN
        rk_dec = 1'b0;
`endif
        init_sbox();
        test_reset();
        test_expand_128();
        test_read();
        test_start_ignored();
        test_reset_abort();
        test_read_with_start();
        test_aes256();
`ifdef KEYSCHED_DECRYPT_EN
        test_decrypt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
